// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
//
// Turns the debounced key_value/key_flag pair into single-cycle gesture
// events for the UI logic: short press, long press, double click and,
// optionally, auto-repeat while the key is held after a long press.
//
// Optional feature macro: KEY_REPEAT_EN
//   defined   - LHOLD runs a repeat counter and key_repeat pulses every
//               REPEAT_CNT cycles while the key stays held.
//   undefined - repeat logic is not built, key_repeat is constant 0 and
//               REPEAT_CNT is unused.
//
// Parameters (all must satisfy 2 <= N < 2^32):
//   LONG_CNT   - hold cycles before a press becomes a long press
//   DCLICK_CNT - cycles after release to wait for a second press
//   REPEAT_CNT - auto-repeat period while long-held
//
// Ports:
//   sys_clk      in   system clock
//   sys_rst      in   synchronous active-high reset
//   key_value    in   debounced level, 0 = pressed, 1 = released
//   key_flag     in   strobe: key_value newly settled this cycle
//   short_press  out  one-cycle pulse, single short click
//   long_press   out  one-cycle pulse, hold reached LONG_CNT
//   double_click out  one-cycle pulse, second press within window
//   key_repeat   out  one-cycle pulse, auto-repeat tick
//   key_busy     out  high while a gesture is in progress
// -----------------------------------------------------------------------------
module key_event_decoder #(
  parameter int unsigned LONG_CNT   = 32'd50_000_000,
  parameter int unsigned DCLICK_CNT = 32'd12_500_000,
  parameter int unsigned REPEAT_CNT = 32'd5_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_value,
  input  logic key_flag,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic key_repeat,
  output logic key_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LHOLD  = 3'd4
  } state_t;

  localparam logic [31:0] LONG_LAST   = 32'(LONG_CNT - 32'd1);
  localparam logic [31:0] DCLICK_LAST = 32'(DCLICK_CNT - 32'd1);
`ifdef KEY_REPEAT_EN
  localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CNT - 32'd1);
`endif

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        short_q, short_d;
  logic        long_q, long_d;
  logic        dbl_q, dbl_d;
  logic        rep_q, rep_d;
  logic        busy_q, busy_d;

  logic        press_s;
  logic        release_s;
  logic [31:0] cnt_inc_s;

  assign press_s   = key_flag & ~key_value;
  assign release_s = key_flag & key_value;
  // Saturate so a very long hold in LHOLD can never wrap the counter.
  assign cnt_inc_s = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : (cnt_q + 32'd1);

  // Next-state, counter and event-pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    rep_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_s) begin
          state_d = PRESS1;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = 32'd0;
        end
      end
      PRESS1: begin
        // Release is checked first so it wins a tie with the long timeout.
        if (release_s) begin
          state_d = WAIT2;
          cnt_d   = 32'd0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LHOLD;
          cnt_d   = 32'd0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      WAIT2: begin
        // Second press wins a tie with the double-click window timeout.
        if (press_s) begin
          state_d = PRESS2;
          cnt_d   = 32'd0;
        end else if (cnt_q == DCLICK_LAST) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      PRESS2: begin
        if (release_s) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
          dbl_d   = 1'b1;
        end else begin
          cnt_d = 32'd0;
        end
      end
      LHOLD: begin
        // Release wins a tie with a repeat tick: no key_repeat on release.
        if (release_s) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
`ifdef KEY_REPEAT_EN
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d = 32'd0;
          rep_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
      end
    endcase
    // Busy follows the next state but also covers the cycle carrying the
    // terminating short/double pulse, so the gesture and its result overlap.
    busy_d = (state_d != IDLE) | short_d | dbl_d;
  end

  // State, counter and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      rep_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      rep_q   <= rep_d;
      busy_q  <= busy_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dbl_q;
  assign key_repeat   = rep_q;
  assign key_busy     = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_key_event_decoder
//
// Directed bench for key_event_decoder with LONG_CNT=20, DCLICK_CNT=10,
// REPEAT_CNT=5. Each scenario drives key events at chosen cycles (cycle 0 is
// the first cycle after the reset pulse), records every output per cycle into
// a bit vector, and compares it with a hand-built expected vector.
// -----------------------------------------------------------------------------
module tb_key_event_decoder;

  localparam int unsigned LONG_CNT   = 20;
  localparam int unsigned DCLICK_CNT = 10;
  localparam int unsigned REPEAT_CNT = 5;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic key_value;
  logic key_flag;
  logic short_press;
  logic long_press;
  logic double_click;
  logic key_repeat;
  logic key_busy;

  int checks = 0;
  int errors = 0;

  // Event schedule shared by the scenario tasks and the cycle runner.
  int   ev_cyc [8];
  logic ev_val [8];
  int   n_ev;
  int   rst_cyc;

  logic [63:0] sp_v, lp_v, dc_v, kr_v, bz_v;

  key_event_decoder #(
    .LONG_CNT  (LONG_CNT),
    .DCLICK_CNT(DCLICK_CNT),
    .REPEAT_CNT(REPEAT_CNT)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_value   (key_value),
    .key_flag    (key_flag),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .key_repeat  (key_repeat),
    .key_busy    (key_busy)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [63:0] bit_at(input int c);
    logic [63:0] v;
    v = 64'd0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] v;
    v = 64'd0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Reset, then run ncyc cycles applying the schedule and recording outputs.
  task automatic run(input int ncyc);
    sp_v = 64'd0; lp_v = 64'd0; dc_v = 64'd0; kr_v = 64'd0; bz_v = 64'd0;
    sys_rst   = 1'b1;
    key_flag  = 1'b0;
    key_value = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    for (int c = 0; c < ncyc; c++) begin
      key_flag = 1'b0;
      sys_rst  = (c == rst_cyc);
      for (int e = 0; e < n_ev; e++) begin
        if (ev_cyc[e] == c) begin
          key_flag  = 1'b1;
          key_value = ev_val[e];
        end
      end
      @(negedge sys_clk);
      sp_v[c] = short_press;
      lp_v[c] = long_press;
      dc_v[c] = double_click;
      kr_v[c] = key_repeat;
      bz_v[c] = key_busy;
      @(posedge sys_clk);
      #1;
    end
    key_flag = 1'b0;
    sys_rst  = 1'b0;
  endtask

  task automatic test_reset;
    // A press seen during reset must be ignored; the held key gives nothing.
    sys_rst   = 1'b1;
    key_flag  = 1'b1;
    key_value = 1'b0;
    @(posedge sys_clk);
    #1;
    key_flag = 1'b0;
    sys_rst  = 1'b0;
    @(negedge sys_clk);
    checks++;
    if ({short_press, long_press, double_click, key_repeat} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_events got %b want 0000",
               {short_press, long_press, double_click, key_repeat});
    end
    checks++;
    if (key_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", key_busy);
    end
    repeat (25) @(negedge sys_clk);
    checks++;
    if ({long_press, key_busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_held_key got long/busy %b want 00", {long_press, key_busy});
    end
  endtask

  task automatic test_short;
    n_ev = 2; rst_cyc = -1;
    ev_cyc[0] = 0; ev_val[0] = 1'b0;
    ev_cyc[1] = 5; ev_val[1] = 1'b1;
    run(40);
    checks++;
    if (sp_v !== bit_at(16)) begin errors++; $display("FAIL short_sp got %h want %h", sp_v, bit_at(16)); end
    checks++;
    if ((lp_v | dc_v | kr_v) !== 64'd0) begin errors++; $display("FAIL short_others got %h want 0", lp_v | dc_v | kr_v); end
    checks++;
    if (bz_v !== span(1, 16)) begin errors++; $display("FAIL short_busy got %h want %h", bz_v, span(1, 16)); end
  endtask

  task automatic test_long_repeat;
    logic [63:0] exp_kr;
`ifdef KEY_REPEAT_EN
    exp_kr = bit_at(26) | bit_at(31) | bit_at(36);
`else
    exp_kr = 64'd0;
`endif
    n_ev = 2; rst_cyc = -1;
    ev_cyc[0] = 0;  ev_val[0] = 1'b0;
    ev_cyc[1] = 38; ev_val[1] = 1'b1;
    run(55);
    checks++;
    if (lp_v !== bit_at(21)) begin errors++; $display("FAIL long_lp got %h want %h", lp_v, bit_at(21)); end
    checks++;
    if (kr_v !== exp_kr) begin errors++; $display("FAIL long_repeat got %h want %h", kr_v, exp_kr); end
    checks++;
    if ((sp_v | dc_v) !== 64'd0) begin errors++; $display("FAIL long_others got %h want 0", sp_v | dc_v); end
    checks++;
    if (bz_v !== span(1, 38)) begin errors++; $display("FAIL long_busy got %h want %h", bz_v, span(1, 38)); end
  endtask

  task automatic test_double;
    n_ev = 4; rst_cyc = -1;
    ev_cyc[0] = 0;  ev_val[0] = 1'b0;
    ev_cyc[1] = 4;  ev_val[1] = 1'b1;
    ev_cyc[2] = 8;  ev_val[2] = 1'b0;
    ev_cyc[3] = 12; ev_val[3] = 1'b1;
    run(40);
    checks++;
    if (dc_v !== bit_at(13)) begin errors++; $display("FAIL dbl_dc got %h want %h", dc_v, bit_at(13)); end
    checks++;
    if ((sp_v | lp_v | kr_v) !== 64'd0) begin errors++; $display("FAIL dbl_others got %h want 0", sp_v | lp_v | kr_v); end
    checks++;
    if (bz_v !== span(1, 13)) begin errors++; $display("FAIL dbl_busy got %h want %h", bz_v, span(1, 13)); end
  endtask

  task automatic test_tie_long;
    // Release one cycle before the timeout cycle.
    n_ev = 2; rst_cyc = -1;
    ev_cyc[0] = 0;  ev_val[0] = 1'b0;
    ev_cyc[1] = 19; ev_val[1] = 1'b1;
    run(45);
    checks++;
    if (sp_v !== bit_at(30)) begin errors++; $display("FAIL tie19_sp got %h want %h", sp_v, bit_at(30)); end
    checks++;
    if (lp_v !== 64'd0) begin errors++; $display("FAIL tie19_lp got %h want 0", lp_v); end
    // Release exactly in the cycle where cnt == LONG_CNT-1.
    ev_cyc[1] = 20;
    run(45);
    checks++;
    if (sp_v !== bit_at(31)) begin errors++; $display("FAIL tie20_sp got %h want %h", sp_v, bit_at(31)); end
    checks++;
    if ((lp_v | kr_v) !== 64'd0) begin errors++; $display("FAIL tie20_lp got %h want 0", lp_v | kr_v); end
  endtask

  task automatic test_tie_dclick;
    n_ev = 4; rst_cyc = -1;
    ev_cyc[0] = 0;  ev_val[0] = 1'b0;
    ev_cyc[1] = 3;  ev_val[1] = 1'b1;
    ev_cyc[2] = 13; ev_val[2] = 1'b0;
    ev_cyc[3] = 15; ev_val[3] = 1'b1;
    run(40);
    checks++;
    if (dc_v !== bit_at(16)) begin errors++; $display("FAIL tiedc_dc got %h want %h", dc_v, bit_at(16)); end
    checks++;
    if ((sp_v | lp_v) !== 64'd0) begin errors++; $display("FAIL tiedc_sp got %h want 0", sp_v | lp_v); end
    checks++;
    if (bz_v !== span(1, 16)) begin errors++; $display("FAIL tiedc_busy got %h want %h", bz_v, span(1, 16)); end
  endtask

  task automatic test_reset_abort;
    n_ev = 3; rst_cyc = 10;
    ev_cyc[0] = 0;  ev_val[0] = 1'b0;
    ev_cyc[1] = 25; ev_val[1] = 1'b1;
    ev_cyc[2] = 30; ev_val[2] = 1'b0;
    run(60);
    // After reset the new press at 30 is held, so the long press lands at 51.
    checks++;
    if (lp_v !== bit_at(51)) begin errors++; $display("FAIL abort_lp got %h want %h", lp_v, bit_at(51)); end
    checks++;
    if ((sp_v | dc_v) !== 64'd0) begin errors++; $display("FAIL abort_others got %h want 0", sp_v | dc_v); end
    checks++;
    if (bz_v !== (span(1, 10) | span(31, 59))) begin
      errors++;
      $display("FAIL abort_busy got %h want %h", bz_v, span(1, 10) | span(31, 59));
    end
  endtask

  initial begin
    sys_rst   = 1'b1;
    key_flag  = 1'b0;
    key_value = 1'b1;
    n_ev      = 0;
    rst_cyc   = -1;
    @(posedge sys_clk);
    #1;
    test_reset;
    test_short;
    test_long_repeat;
    test_double;
    test_tie_long;
    test_tie_dclick;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
